// File: rtl/mbist_serial_sched.sv
// Serial memory-BIST scheduler: walks the masked tile test stubs one at a
// time, sends each a six-bit setup frame on its enable line, holds the
// enable through the run, and records per-stub fail / timeout status.
module mbist_serial_sched #(
   parameter int NUM_STUBS = 4,
   parameter int TO_W      = 16,
   parameter int MIN_WAIT  = 16,
   parameter int GAP       = 4
) (
   input  logic                 rclk,
   input  logic                 grst,
   input  logic                 sched_start,
   input  logic                 sched_abort,
   input  logic [NUM_STUBS-1:0] sched_mask,
   input  logic [4:0]           sched_cfg,
   input  logic [TO_W-1:0]      sched_timeout,
   input  logic [NUM_STUBS-1:0] tst_mbist_done,
   input  logic [NUM_STUBS-1:0] tst_mbist_fail,
   output logic [NUM_STUBS-1:0] tst_mbist_enable,
   output logic                 sched_busy,
   output logic                 sched_done,
   output logic [3:0]           sched_cur,
   output logic [NUM_STUBS-1:0] sched_fail_vec,
   output logic [NUM_STUBS-1:0] sched_to_vec,
   output logic                 sched_abort_flag
);

   // Run counter must reach timeout-1+MIN_WAIT for the largest timeout.
   localparam int CNT_W = TO_W + $clog2(MIN_WAIT + 2);
   localparam int GAP_W = $clog2(GAP + 1);
   localparam int PTR_W = 5;

   localparam logic [NUM_STUBS-1:0] ONE     = NUM_STUBS'(1);
   localparam logic [CNT_W-1:0]     CNT_MAX = '1;
   localparam logic [CNT_W-1:0]     MW_C    = CNT_W'(MIN_WAIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEL,
      S_FRAME,
      S_RUN,
      S_GAP,
      S_FIN
   } state_t;

   state_t                state_q, state_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic [3:0]            cur_q, cur_d;
   logic [2:0]            fidx_q, fidx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [GAP_W-1:0]      gcnt_q, gcnt_d;
   logic [NUM_STUBS-1:0]  mask_q, mask_d;
   logic [4:0]            cfg_q, cfg_d;
   logic [TO_W-1:0]       tmo_q, tmo_d;
   logic [NUM_STUBS-1:0]  enable_q, enable_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [NUM_STUBS-1:0]  fail_q, fail_d;
   logic [NUM_STUBS-1:0]  to_q, to_d;
   logic                  abrt_q, abrt_d;

   logic                  sel_found;
   logic [3:0]            sel_idx;
   logic [NUM_STUBS-1:0]  cur_onehot;
   logic [NUM_STUBS-1:0]  sel_onehot;
   logic                  done_cur;
   logic                  qual_done;
   logic [CNT_W-1:0]      tmo_lim;
   logic [5:0]            frame_bits;
   logic [2:0]            fidx_nxt;

   // Counter increments stick at all-ones so a very long run cannot wrap
   // back into the qualification window.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // Lowest masked stub at or above the scan pointer.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = NUM_STUBS - 1; i >= 0; i--) begin
         if (mask_q[i] && (PTR_W'(i) >= ptr_q)) begin
            sel_found = 1'b1;
            sel_idx   = 4'(i);
         end
      end
   end

   assign cur_onehot = ONE << cur_q;
   assign sel_onehot = ONE << sel_idx;
   assign done_cur   = |(tst_mbist_done & cur_onehot);
   assign qual_done  = done_cur && (cnt_q >= MW_C);
   assign tmo_lim    = CNT_W'(tmo_q) + MW_C - CNT_W'(1);
   // Marker first, then data_mode, loop_on_addr, loop, stop_on_fail,
   // stop_on_next_fail.
   assign frame_bits = {cfg_q, 1'b1};
   assign fidx_nxt   = fidx_q + 3'd1;

   // Next-state and next-output computation for the scheduler.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cur_d    = cur_q;
      fidx_d   = fidx_q;
      cnt_d    = cnt_q;
      gcnt_d   = gcnt_q;
      mask_d   = mask_q;
      cfg_d    = cfg_q;
      tmo_d    = tmo_q;
      busy_d   = busy_q;
      fail_d   = fail_q;
      to_d     = to_q;
      abrt_d   = abrt_q;
      enable_d = '0;

      case (state_q)
         S_IDLE: begin
            if (sched_start) begin
               fail_d  = '0;
               to_d    = '0;
               abrt_d  = 1'b0;
               mask_d  = sched_mask;
               cfg_d   = sched_cfg;
               tmo_d   = sched_timeout;
               busy_d  = 1'b1;
               ptr_d   = '0;
               state_d = S_SEL;
            end
         end

         S_SEL: begin
            if (sched_abort) begin
               abrt_d  = 1'b1;
               state_d = S_FIN;
            end else if (sel_found) begin
               cur_d    = sel_idx;
               fidx_d   = '0;
               enable_d = sel_onehot;
               state_d  = S_FRAME;
            end else begin
               state_d = S_FIN;
            end
         end

         S_FRAME: begin
            if (sched_abort) begin
               abrt_d  = 1'b1;
               state_d = S_FIN;
            end else if (fidx_q == 3'd5) begin
               cnt_d    = '0;
               enable_d = cur_onehot;
               state_d  = S_RUN;
            end else begin
               fidx_d   = fidx_nxt;
               enable_d = frame_bits[fidx_nxt] ? cur_onehot : '0;
            end
         end

         S_RUN: begin
            if (qual_done) begin
               // A done seen together with abort is still recorded.
               fail_d = fail_q | (cur_onehot & tst_mbist_fail);
               gcnt_d = '0;
               if (sched_abort) begin
                  abrt_d  = 1'b1;
                  state_d = S_FIN;
               end else begin
                  state_d = S_GAP;
               end
            end else if (sched_abort) begin
               abrt_d  = 1'b1;
               state_d = S_FIN;
            end else if ((tmo_q != '0) && (cnt_q == tmo_lim)) begin
               fail_d  = fail_q | cur_onehot;
               to_d    = to_q | cur_onehot;
               gcnt_d  = '0;
               state_d = S_GAP;
            end else begin
               cnt_d    = sat_inc(cnt_q);
               enable_d = cur_onehot;
            end
         end

         S_GAP: begin
            if (sched_abort) begin
               abrt_d  = 1'b1;
               state_d = S_FIN;
            end else if (gcnt_q == GAP_W'(GAP - 1)) begin
               if (cur_q == 4'(NUM_STUBS - 1)) begin
                  state_d = S_FIN;
               end else begin
                  ptr_d   = PTR_W'(cur_q) + PTR_W'(1);
                  state_d = S_SEL;
               end
            end else begin
               gcnt_d = gcnt_q + GAP_W'(1);
            end
         end

         S_FIN: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      done_d = (state_d == S_FIN);
   end

   // State and registered outputs; reset clears everything including status.
   always_ff @(posedge rclk) begin
      if (grst) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         cur_q    <= '0;
         fidx_q   <= '0;
         cnt_q    <= '0;
         gcnt_q   <= '0;
         mask_q   <= '0;
         cfg_q    <= '0;
         tmo_q    <= '0;
         enable_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fail_q   <= '0;
         to_q     <= '0;
         abrt_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cur_q    <= cur_d;
         fidx_q   <= fidx_d;
         cnt_q    <= cnt_d;
         gcnt_q   <= gcnt_d;
         mask_q   <= mask_d;
         cfg_q    <= cfg_d;
         tmo_q    <= tmo_d;
         enable_q <= enable_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         fail_q   <= fail_d;
         to_q     <= to_d;
         abrt_q   <= abrt_d;
      end
   end

   assign tst_mbist_enable = enable_q;
   assign sched_busy       = busy_q;
   assign sched_done       = done_q;
   assign sched_cur        = cur_q;
   assign sched_fail_vec   = fail_q;
   assign sched_to_vec     = to_q;
   assign sched_abort_flag = abrt_q;

endmodule

// File: tb/tb_mbist_serial_sched.sv
// Bench for mbist_serial_sched: behavioural test stubs plus a pass-level
// schedule model that predicts the per-cycle enable trace and final status.
module tb_mbist_serial_sched;

   localparam int N    = 4;
   localparam int TO_W = 16;
   localparam int MW   = 16;
   localparam int GAPC = 4;
   localparam int INF  = 1000000;

   logic            rclk = 1'b0;
   logic            grst;
   logic            sched_start;
   logic            sched_abort;
   logic [N-1:0]    sched_mask;
   logic [4:0]      sched_cfg;
   logic [TO_W-1:0] sched_timeout;
   logic [N-1:0]    tst_mbist_done;
   logic [N-1:0]    tst_mbist_fail;
   logic [N-1:0]    tst_mbist_enable;
   logic            sched_busy;
   logic            sched_done;
   logic [3:0]      sched_cur;
   logic [N-1:0]    sched_fail_vec;
   logic [N-1:0]    sched_to_vec;
   logic            sched_abort_flag;

   mbist_serial_sched #(.NUM_STUBS(N), .TO_W(TO_W), .MIN_WAIT(MW), .GAP(GAPC)) dut (
      .rclk             (rclk),
      .grst             (grst),
      .sched_start      (sched_start),
      .sched_abort      (sched_abort),
      .sched_mask       (sched_mask),
      .sched_cfg        (sched_cfg),
      .sched_timeout    (sched_timeout),
      .tst_mbist_done   (tst_mbist_done),
      .tst_mbist_fail   (tst_mbist_fail),
      .tst_mbist_enable (tst_mbist_enable),
      .sched_busy       (sched_busy),
      .sched_done       (sched_done),
      .sched_cur        (sched_cur),
      .sched_fail_vec   (sched_fail_vec),
      .sched_to_vec     (sched_to_vec),
      .sched_abort_flag (sched_abort_flag)
   );

   always #5 rclk = ~rclk;

   int n_assert = 0;
   int n_fail   = 0;

   // Stub behaviour: done rises d_delay cycles into the run (-1: never);
   // stale stubs hold done high permanently.
   int  d_delay [N];
   bit  f_val   [N];
   bit  stale   [N];
   int  k       [N];
   bit  act     [N];
   bit  prev_en [N];

   // Model results.
   int  exp_en  [$];
   int  exp_cur [$];
   int  end_idx   [N];
   int  run_start [N];
   bit  res_fail  [N];
   bit  res_to    [N];

   initial begin
      tst_mbist_done = '0;
      tst_mbist_fail = '0;
      forever begin
         @(negedge rclk);
         for (int i = 0; i < N; i++) begin
            if (tst_mbist_enable[i] && !prev_en[i] && (!act[i] || k[i] >= 6)) begin
               act[i] = 1'b1;
               k[i]   = 0;
            end else if (act[i]) begin
               k[i] = k[i] + 1;
            end
            prev_en[i] = tst_mbist_enable[i];
            tst_mbist_done[i] = stale[i] ||
               (act[i] && d_delay[i] >= 0 && k[i] >= 6 + d_delay[i]);
            tst_mbist_fail[i] = f_val[i];
         end
      end
   end

   // Expected pass: one SEL cycle, then per masked stub a 6-bit frame, the
   // run, GAP idle cycles and a SEL cycle unless it was the top stub; FIN last.
   task automatic build_expected(input logic [N-1:0] mask, input logic [4:0] cfg,
                                 input logic [TO_W-1:0] tmo);
      int eff, acc, lim, run_len;
      exp_en.delete();
      exp_cur.delete();
      exp_en.push_back(0); exp_cur.push_back(-1);
      for (int s = 0; s < N; s++) begin
         end_idx[s] = INF; run_start[s] = INF; res_fail[s] = 0; res_to[s] = 0;
         if (mask[s]) begin
            for (int b = 0; b < 6; b++) begin
               exp_en.push_back(((b == 0) || cfg[b-1]) ? (1 << s) : 0);
               exp_cur.push_back(s);
            end
            eff = stale[s] ? 0 : d_delay[s];
            acc = (eff < 0) ? INF : ((eff < MW) ? MW : eff);
            lim = (tmo != 0) ? int'(tmo) - 1 + MW : INF;
            if (lim < acc) begin
               run_len = lim + 1; res_to[s] = 1; res_fail[s] = 1;
            end else begin
               run_len = acc + 1; res_fail[s] = f_val[s];
            end
            run_start[s] = exp_en.size();
            for (int r = 0; r < run_len; r++) begin
               exp_en.push_back(1 << s); exp_cur.push_back(s);
            end
            end_idx[s] = exp_en.size() - 1;
            for (int g = 0; g < GAPC; g++) begin
               exp_en.push_back(0); exp_cur.push_back(s);
            end
            if (s != N - 1) begin
               exp_en.push_back(0); exp_cur.push_back(-1);
            end
         end
      end
      exp_en.push_back(0); exp_cur.push_back(-1);
   endtask

   task automatic run_pass(input string name, input logic [N-1:0] mask,
                           input logic [4:0] cfg, input logic [TO_W-1:0] tmo,
                           input int abort_at, input int glitch_at);
      int last;
      logic [N-1:0] efv, etv;
      logic eab, edone;
      build_expected(mask, cfg, tmo);
      if (abort_at >= 0 && abort_at < exp_en.size() - 1) begin
         while (exp_en.size() > abort_at + 1) begin
            void'(exp_en.pop_back()); void'(exp_cur.pop_back());
         end
         exp_en.push_back(0); exp_cur.push_back(-1);
      end
      efv = '0; etv = '0;
      for (int s = 0; s < N; s++) begin
         if (abort_at < 0 || (res_to[s] ? end_idx[s] < abort_at : end_idx[s] <= abort_at)) begin
            efv[s] = res_fail[s]; etv[s] = res_to[s];
         end
      end
      eab  = (abort_at >= 0);
      last = exp_en.size() - 1;
      repeat (5) @(negedge rclk);
      sched_mask = mask; sched_cfg = cfg; sched_timeout = tmo; sched_start = 1'b1;
      @(negedge rclk);
      sched_start = 1'b0;
      sched_mask = N'($urandom); sched_cfg = 5'($urandom); sched_timeout = TO_W'($urandom);
      for (int j = 0; j <= last; j++) begin
         if (j > 0) @(negedge rclk);
         sched_start = 1'b0; sched_abort = 1'b0;
         edone = (j == last);
         n_assert++;
         if (tst_mbist_enable !== N'(exp_en[j]) || sched_busy !== 1'b1 || sched_done !== edone ||
             (exp_cur[j] >= 0 && sched_cur !== 4'(exp_cur[j]))) begin
            n_fail++;
            $display("FAIL %s cycle %0d: en=%b busy=%b done=%b cur=%0d, required en=%b busy=1 done=%b cur=%0d",
                     name, j, tst_mbist_enable, sched_busy, sched_done, sched_cur,
                     N'(exp_en[j]), edone, exp_cur[j]);
         end
         if (j == abort_at) sched_abort = 1'b1;
         if (j == glitch_at) begin
            sched_start = 1'b1; sched_mask = N'($urandom);
         end
      end
      @(negedge rclk);
      sched_start = 1'b0; sched_abort = 1'b0;
      n_assert++;
      if (sched_busy !== 1'b0 || sched_done !== 1'b0 || tst_mbist_enable !== '0 ||
          sched_fail_vec !== efv || sched_to_vec !== etv || sched_abort_flag !== eab) begin
         n_fail++;
         $display("FAIL %s end: busy=%b done=%b en=%b fail=%b to=%b abort=%b, required busy=0 done=0 en=0 fail=%b to=%b abort=%b",
                  name, sched_busy, sched_done, tst_mbist_enable, sched_fail_vec, sched_to_vec,
                  sched_abort_flag, efv, etv, eab);
      end
   endtask

   task automatic set_stubs(input int d, input bit f);
      for (int i = 0; i < N; i++) begin
         d_delay[i] = d; f_val[i] = f; stale[i] = 0;
      end
   endtask

   task automatic check_all_zero(input string name);
      n_assert++;
      if ({tst_mbist_enable, sched_busy, sched_done, sched_cur, sched_fail_vec,
           sched_to_vec, sched_abort_flag} !== '0) begin
         n_fail++;
         $display("FAIL %s: en=%b busy=%b done=%b cur=%0d fail=%b to=%b abort=%b, required all 0",
                  name, tst_mbist_enable, sched_busy, sched_done, sched_cur, sched_fail_vec,
                  sched_to_vec, sched_abort_flag);
      end
   endtask

   task automatic check_vec(input string name, input logic [N-1:0] act_v, input logic [N-1:0] req);
      n_assert++;
      if (act_v !== req) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b", name, act_v, req);
      end
   endtask

   task automatic test_reset();
      grst = 1'b1;
      repeat (3) @(negedge rclk);
      check_all_zero("reset_held");
      grst = 1'b0;
      @(negedge rclk);
      check_all_zero("reset_released");
   endtask

   task automatic test_basic();
      set_stubs(30, 0);
      run_pass("basic_0101", 4'b0101, 5'b00001, '0, -1, -1);
      check_vec("basic_fail_vec", sched_fail_vec, 4'b0000);
   endtask

   task automatic test_fail_all();
      set_stubs(30, 0);
      f_val[2] = 1;
      run_pass("fail_1111", 4'b1111, 5'b10110, '0, -1, -1);
      check_vec("fail_all_fail_vec", sched_fail_vec, 4'b0100);
      check_vec("fail_all_to_vec", sched_to_vec, 4'b0000);
   endtask

   task automatic test_timeout();
      set_stubs(-1, 0);
      run_pass("timeout_0010", 4'b0010, 5'b00000, 16'd8, -1, -1);
      check_vec("timeout_to_vec", sched_to_vec, 4'b0010);
      check_vec("timeout_fail_vec", sched_fail_vec, 4'b0010);
   endtask

   task automatic test_stale_done();
      set_stubs(5, 0);
      stale[0] = 1;
      repeat (3) @(negedge rclk);
      run_pass("stale_done", 4'b0001, 5'b11111, '0, -1, -1);
      stale[0] = 0;
   endtask

   task automatic test_abort();
      set_stubs(30, 1);
      build_expected(4'b1111, 5'b00001, '0);
      run_pass("abort_run1", 4'b1111, 5'b00001, '0, run_start[1] + 10, -1);
      check_vec("abort_fail_vec", sched_fail_vec, 4'b0001);
      check_vec("abort_to_vec", sched_to_vec, 4'b0000);
   endtask

   task automatic test_reset_mid_frame();
      set_stubs(20, 0);
      repeat (5) @(negedge rclk);
      sched_mask = 4'b1111; sched_cfg = 5'b01010; sched_timeout = '0; sched_start = 1'b1;
      @(negedge rclk);
      sched_start = 1'b0;
      repeat (3) @(negedge rclk);
      grst = 1'b1;
      @(negedge rclk);
      grst = 1'b0;
      check_all_zero("reset_mid_frame");
      @(negedge rclk);
      check_all_zero("reset_mid_frame_idle");
      run_pass("restart_after_reset", 4'b1111, 5'b01010, '0, -1, -1);
   endtask

   task automatic test_mask_zero();
      run_pass("mask_zero_start_in_fin", 4'b0000, 5'b00000, '0, -1, 1);
   endtask

   task automatic test_back_to_back();
      set_stubs(20, 0);
      run_pass("busy_start_ignored", 4'b1001, 5'b00100, '0, -1, 12);
      run_pass("back_to_back", 4'b0110, 5'b01000, 16'd3, -1, -1);
   endtask

   task automatic test_random();
      logic [N-1:0]    m;
      logic [4:0]      c;
      logic [TO_W-1:0] t;
      for (int it = 0; it < 8; it++) begin
         m = N'($urandom);
         c = 5'($urandom);
         t = ($urandom_range(0, 2) == 0) ? '0 : TO_W'($urandom_range(1, 30));
         for (int i = 0; i < N; i++) begin
            d_delay[i] = $urandom_range(0, 40);
            if (t != 0 && $urandom_range(0, 3) == 0) d_delay[i] = -1;
            f_val[i] = 1'($urandom);
            stale[i] = ($urandom_range(0, 5) == 0);
         end
         run_pass($sformatf("random_%0d", it), m, c, t, -1, $urandom_range(1, 40));
      end
      set_stubs(20, 0);
   endtask

   initial begin
      grst = 1'b1; sched_start = 1'b0; sched_abort = 1'b0;
      sched_mask = '0; sched_cfg = '0; sched_timeout = '0;
      for (int i = 0; i < N; i++) begin
         d_delay[i] = -1; f_val[i] = 0; stale[i] = 0; k[i] = 0; act[i] = 0; prev_en[i] = 0;
      end
      test_reset();
      test_basic();
      test_fail_all();
      test_timeout();
      test_stale_done();
      test_abort();
      test_reset_mid_frame();
      test_mask_zero();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
